// File: rtl/lcd_pkg.sv
// Shared LCD timing defaults, pattern-select encoding and colour-bar palette.
package lcd_pkg;

  localparam int unsigned DEF_CLK_DIV  = 7;
  localparam int unsigned DEF_H_ACTIVE = 800;
  localparam int unsigned DEF_H_FP     = 40;
  localparam int unsigned DEF_H_SYNC   = 48;
  localparam int unsigned DEF_H_BP     = 40;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 13;
  localparam int unsigned DEF_V_SYNC   = 3;
  localparam int unsigned DEF_V_BP     = 29;

  typedef enum logic [1:0] {
    PAT_BARS    = 2'd0,
    PAT_GRAY    = 2'd1,
    PAT_WHITE   = 2'd2,
    PAT_CHECKER = 2'd3
  } pattern_e;

  // Colours packed as {R[5:0], G[5:0], B[5:0]}
  localparam logic [17:0] COL_WHITE   = {6'h3F, 6'h3F, 6'h3F};
  localparam logic [17:0] COL_YELLOW  = {6'h3F, 6'h3F, 6'h00};
  localparam logic [17:0] COL_CYAN    = {6'h00, 6'h3F, 6'h3F};
  localparam logic [17:0] COL_GREEN   = {6'h00, 6'h3F, 6'h00};
  localparam logic [17:0] COL_MAGENTA = {6'h3F, 6'h00, 6'h3F};
  localparam logic [17:0] COL_RED     = {6'h3F, 6'h00, 6'h00};
  localparam logic [17:0] COL_BLUE    = {6'h00, 6'h00, 6'h3F};
  localparam logic [17:0] COL_BLACK   = {6'h00, 6'h00, 6'h00};

  // Bar order left to right across the active line
  function automatic logic [17:0] bar_colour(input logic [2:0] idx);
    logic [17:0] c;
    case (idx)
      3'd0:    c = COL_WHITE;
      3'd1:    c = COL_YELLOW;
      3'd2:    c = COL_CYAN;
      3'd3:    c = COL_GREEN;
      3'd4:    c = COL_MAGENTA;
      3'd5:    c = COL_RED;
      3'd6:    c = COL_BLUE;
      default: c = COL_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lcd_pattern_gen.sv
// Test-pattern colour generator: 18-bit RGB for the current pixel.
// Only the low six bits of h/v influence any pattern, so only those are ported.
module lcd_pattern_gen
  import lcd_pkg::*;
(
  input  logic [5:0]  h,
  input  logic [5:0]  v,
  input  logic [2:0]  bar,
  input  pattern_e    pattern,
  output logic [17:0] rgb
);

  // Select colour for the active pattern
  always_comb begin
    rgb = '0;
    case (pattern)
      PAT_BARS:    rgb = bar_colour(bar);
      PAT_GRAY:    rgb = {h, h, h};
      PAT_WHITE:   rgb = COL_WHITE;
      PAT_CHECKER: rgb = (h[5] ^ v[5]) ? COL_WHITE : COL_BLACK;
      default:     rgb = '0;
    endcase
  end

endmodule

// File: rtl/lcd_timing_gen.sv
// LCD raster timing generator producing three 7-bit serialiser words per pixel.
module lcd_timing_gen
  import lcd_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic        CLK100MHZ,
  input  logic        rst,
  input  logic [1:0]  pattern_sel,
  output logic [6:0]  word_ch1,
  output logic [6:0]  word_ch2,
  output logic [6:0]  word_ch3,
  output logic        word_load,
  output logic        frame_start,
  output logic [10:0] hcount,
  output logic [10:0] vcount
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] BAR_LAST = 11'(H_ACTIVE / 8 - 1);

  logic [DIV_W-1:0] div;
  logic             pix_stb;
  logic [10:0]      h, v;
  logic [10:0]      bar_px;
  logic [2:0]       bar_idx;
  pattern_e         pat_q;
  pattern_e         pat_eff;
  logic             at_origin;
  logic [17:0]      rgb;
  logic [17:0]      rgb_vis;
  logic             de, hs, vs;
  logic [6:0]       ch1_d, ch2_d, ch3_d;

  assign pix_stb   = (div == DIV_LAST);
  assign at_origin = (h == '0) && (v == '0);

  // Pixel-rate divider
  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst)          div <= '0;
    else if (pix_stb) div <= '0;
    else              div <= div + 1'b1;
  end

  // Horizontal / vertical raster position
  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (pix_stb) begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  // Colour-bar index tracked by a pixel counter within each bar;
  // the index wraps harmlessly past the active region where DE masks colour.
  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (pix_stb) begin
      if (h == H_LAST) begin
        bar_px  <= '0;
        bar_idx <= '0;
      end else if (h < H_ACT) begin
        if (bar_px == BAR_LAST) begin
          bar_px  <= '0;
          bar_idx <= bar_idx + 1'b1;
        end else begin
          bar_px <= bar_px + 1'b1;
        end
      end
    end
  end

  // Latch the pattern select once per frame at pixel (0,0)
  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst)                       pat_q <= PAT_BARS;
    else if (pix_stb && at_origin) pat_q <= pattern_e'(pattern_sel);
  end

  // Pixel (0,0) already uses the freshly sampled select so the new pattern
  // starts exactly with frame_start.
  always_comb begin
    pat_eff = at_origin ? pattern_e'(pattern_sel) : pat_q;
  end

  lcd_pattern_gen u_pattern (
    .h       (h[5:0]),
    .v       (v[5:0]),
    .bar     (bar_idx),
    .pattern (pat_eff),
    .rgb     (rgb)
  );

  // Sync/enable decode and word packing
  always_comb begin
    de      = (h < H_ACT) && (v < V_ACT);
    hs      = (h >= HS_BEG) && (h < HS_END);
    vs      = (v >= VS_BEG) && (v < VS_END);
    rgb_vis = de ? rgb : '0;
    ch1_d   = {rgb_vis[6], rgb_vis[17:12]};
    ch2_d   = {rgb_vis[1:0], rgb_vis[11:7]};
    ch3_d   = {de, vs, hs, rgb_vis[5:2]};
  end

  // Output registers, loaded on each pixel strobe
  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      word_ch1    <= '0;
      word_ch2    <= '0;
      word_ch3    <= '0;
      word_load   <= 1'b0;
      frame_start <= 1'b0;
      hcount      <= '0;
      vcount      <= '0;
    end else begin
      word_load   <= pix_stb;
      frame_start <= pix_stb && at_origin;
      if (pix_stb) begin
        word_ch1 <= ch1_d;
        word_ch2 <= ch2_d;
        word_ch3 <= ch3_d;
        hcount   <= h;
        vcount   <= v;
      end
    end
  end

endmodule
